// File: rtl/rotary_pkg.sv
// Shared types and helpers for the rotary encoder path: FSM/direction enums,
// accumulator sizing and the Gray-code direction decoder.
package rotary_pkg;

    localparam int unsigned AB_W  = 2;
    // One spare bit beyond the +/-4 detent span so +4 is representable.
    localparam int unsigned ACC_W = 4;

    localparam logic signed [ACC_W-1:0] ACC_STEP       = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] ACC_DETENT_CW  = ACC_W'(4);
    localparam logic signed [ACC_W-1:0] ACC_DETENT_CCW = ACC_W'(-4);

    typedef enum logic {
        INIT,
        TRACK
    } fsm_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_CW,
        DIR_CCW,
        DIR_ERR
    } qdir_t;

    // CW order is 00 -> 01 -> 11 -> 10 -> 00; a two-bit change is illegal.
    function automatic qdir_t quad_dir(input logic [AB_W-1:0] prev_ab,
                                       input logic [AB_W-1:0] ab);
        qdir_t d;
        d = DIR_ERR;
        case ({prev_ab, ab})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: d = DIR_CW;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: d = DIR_CCW;
            4'b0000, 4'b0101, 4'b1111, 4'b1010: d = DIR_NONE;
            default:                            d = DIR_ERR;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/quad_step.sv
// Quadrature detent tracker: follows A/B phase, accumulates quarter steps and
// emits registered detent-complete and illegal-transition pulses.
module quad_step
    import rotary_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_track,
    input  logic [AB_W-1:0] i_ab,
    output logic            o_up,
    output logic            o_dn,
    output logic            o_err
);

    logic [AB_W-1:0]         r_prev_ab;
    logic signed [ACC_W-1:0] r_acc;

    qdir_t                   w_dir;
    logic signed [ACC_W-1:0] w_acc_upd;
    logic                    w_into_zero;

    always_comb begin
        w_dir       = quad_dir(r_prev_ab, i_ab);
        w_acc_upd   = r_acc;
        w_into_zero = 1'b0;
        case (w_dir)
            DIR_CW:  w_acc_upd = r_acc + ACC_STEP;
            DIR_CCW: w_acc_upd = r_acc - ACC_STEP;
            default: w_acc_upd = r_acc;
        endcase
        w_into_zero = (i_ab == AB_W'(0)) && ((w_dir == DIR_CW) || (w_dir == DIR_CCW));
    end

    // Detent resolves only on entry to 00; anything short of +/-4 is an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_ab <= '0;
            r_acc     <= '0;
            o_up      <= 1'b0;
            o_dn      <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_up      <= 1'b0;
            o_dn      <= 1'b0;
            o_err     <= 1'b0;
            r_prev_ab <= i_ab;
            if (!i_track) begin
                r_acc <= '0;
            end else begin
                case (w_dir)
                    DIR_ERR: begin
                        o_err <= 1'b1;
                        r_acc <= '0;
                    end
                    DIR_CW, DIR_CCW: begin
                        if (w_into_zero) begin
                            o_up  <= (w_acc_upd == ACC_DETENT_CW);
                            o_dn  <= (w_acc_upd == ACC_DETENT_CCW);
                            r_acc <= '0;
                        end else begin
                            r_acc <= w_acc_upd;
                        end
                    end
                    default: r_acc <= r_acc;
                endcase
            end
        end
    end

endmodule

// File: rtl/rotary_ctrl.sv
// Rotary encoder controller: start-up FSM, button edge detect and a bounded
// position counter driven by detent events from quad_step.
module rotary_ctrl
    import rotary_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned CNT_MIN   = 0,
    parameter int unsigned CNT_MAX   = 255,
    parameter int unsigned WRAP      = 1,
    parameter int unsigned BTN_CLEAR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             btn,
    output logic [CNT_W-1:0] count,
    output logic             step_up,
    output logic             step_dn,
    output logic             btn_press,
    output logic             err
);

    localparam logic [CNT_W-1:0] MIN_V = CNT_W'(CNT_MIN);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);

    fsm_t             r_state;
    fsm_t             w_state_next;
    logic             w_track;
    logic             r_btn_q;
    logic             w_press;
    logic             w_q_up;
    logic             w_q_dn;
    logic             w_q_err;
    logic [CNT_W-1:0] w_count_next;
    logic [AB_W-1:0]  w_ab;

    assign w_ab = {enc_a, enc_b};

    quad_step u_quad_step (
        .clk     (clk),
        .rst     (rst),
        .i_track (w_track),
        .i_ab    (w_ab),
        .o_up    (w_q_up),
        .o_dn    (w_q_dn),
        .o_err   (w_q_err)
    );

    // INIT spends exactly one cycle capturing the phase before decoding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= INIT;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_track      = 1'b0;
        case (r_state)
            INIT: begin
                w_state_next = TRACK;
            end
            TRACK: begin
                w_track      = 1'b1;
                w_state_next = TRACK;
            end
            default: w_state_next = INIT;
        endcase
    end

    // Button clear takes priority; a saturated count holds but still pulses.
    always_comb begin
        w_press      = btn & ~r_btn_q;
        w_count_next = count;
        if ((BTN_CLEAR != 0) && w_press) begin
            w_count_next = MIN_V;
        end else if (w_q_up) begin
            if (count == MAX_V) w_count_next = (WRAP != 0) ? MIN_V : count;
            else                w_count_next = count + CNT_W'(1);
        end else if (w_q_dn) begin
            if (count == MIN_V) w_count_next = (WRAP != 0) ? MAX_V : count;
            else                w_count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= MIN_V;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;
            err       <= 1'b0;
            btn_press <= 1'b0;
            r_btn_q   <= 1'b0;
        end else begin
            count     <= w_count_next;
            step_up   <= w_q_up;
            step_dn   <= w_q_dn;
            err       <= w_q_err;
            btn_press <= w_press;
            r_btn_q   <= btn;
        end
    end

endmodule

// File: tb/tb_rotary_ctrl.sv
// Randomized self-checking bench for rotary_ctrl: a wrapping 0..255 instance and
// a saturating 0..9 instance share stimulus and are compared to a phase model.
module tb_rotary_ctrl;

    logic       clk;
    logic       rst;
    logic       enc_a;
    logic       enc_b;
    logic       btn;
    logic [7:0] cnt_w, cnt_s;
    logic       up_w, dn_w, pr_w, er_w;
    logic       up_s, dn_s, pr_s, er_s;

    int n_vec;
    int n_err;
    int cyc;

    // Model state: phase index around the Gray circle, signed quarter-step count.
    int m_prev;
    int m_acc;
    bit m_init;
    bit m_btn_q;
    bit p_up, p_dn, p_err;
    bit e_up, e_dn, e_err, e_press;
    int mc_w, mc_s;
    int r_pos;

    rotary_ctrl u_wrap (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .btn(btn),
        .count(cnt_w), .step_up(up_w), .step_dn(dn_w), .btn_press(pr_w), .err(er_w)
    );

    rotary_ctrl #(.CNT_W(8), .CNT_MIN(0), .CNT_MAX(9), .WRAP(0), .BTN_CLEAR(1)) u_sat (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .btn(btn),
        .count(cnt_s), .step_up(up_s), .step_dn(dn_s), .btn_press(pr_s), .err(er_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int gpos(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        mc_w = 0; mc_s = 0; m_acc = 0; m_init = 1'b1; m_btn_q = 1'b0;
        p_up = 0; p_dn = 0; p_err = 0;
        e_up = 0; e_dn = 0; e_err = 0; e_press = 0;
    endtask

    task automatic model_edge();
        int pos, d;
        e_up    = p_up;
        e_dn    = p_dn;
        e_err   = p_err;
        e_press = btn && !m_btn_q;
        if (e_press) begin
            mc_w = 0; mc_s = 0;
        end else if (p_up) begin
            mc_w = (mc_w + 1) % 256;
            mc_s = (mc_s == 9) ? 9 : mc_s + 1;
        end else if (p_dn) begin
            mc_w = (mc_w + 255) % 256;
            mc_s = (mc_s == 0) ? 0 : mc_s - 1;
        end
        p_up = 0; p_dn = 0; p_err = 0;
        pos = gpos(enc_a, enc_b);
        if (m_init) begin
            m_init = 1'b0;
            m_acc  = 0;
        end else begin
            d = (pos - m_prev + 4) % 4;
            if (d == 2) begin
                p_err = 1;
                m_acc = 0;
            end else if (d != 0) begin
                m_acc += (d == 1) ? 1 : -1;
                if (pos == 0) begin
                    p_up  = (m_acc == 4);
                    p_dn  = (m_acc == -4);
                    m_acc = 0;
                end
            end
        end
        m_prev  = pos;
        m_btn_q = btn;
    endtask

    task automatic check_all();
        chk("count_wrap", 32'(cnt_w), 32'(mc_w));
        chk("count_sat",  32'(cnt_s), 32'(mc_s));
        chk("step_up",    32'(up_w),  32'(e_up));
        chk("step_dn",    32'(dn_w),  32'(e_dn));
        chk("btn_press",  32'(pr_w),  32'(e_press));
        chk("err",        32'(er_w),  32'(e_err));
        chk("sat_pulses", 32'({up_s, dn_s, pr_s, er_s}), 32'({e_up, e_dn, e_press, e_err}));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input int p, input logic bt);
        enc_a = (p == 2) || (p == 3);
        enc_b = (p == 1) || (p == 2);
        btn   = bt;
        r_pos = p;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int p, input logic bt);
        enc_a = (p == 2) || (p == 3);
        enc_b = (p == 1) || (p == 2);
        btn   = bt;
        r_pos = p;
        rst   = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic detent_cw(input int per, input logic bt);
        for (int k = 1; k <= 4; k++)
            for (int j = 0; j < per; j++) tick(k % 4, bt);
    endtask

    task automatic detent_ccw(input int per, input logic bt);
        for (int k = 3; k >= 0; k--)
            for (int j = 0; j < per; j++) tick(k, bt);
    endtask

    initial begin
        int bias, r, stp, th;
        logic bt;
        n_vec = 0; n_err = 0; cyc = 0;
        rst = 1'b1; enc_a = 1'b1; enc_b = 1'b1; btn = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset with 11 held: nothing happens.
        do_reset(2, 1'b0);
        repeat (5) tick(2, 1'b0);
        chk("t1_count", 32'(cnt_w), 32'd0);

        // Walk back to 00 (short, aborted), then one full CW detent.
        repeat (3) tick(3, 1'b0);
        repeat (3) tick(0, 1'b0);
        detent_cw(3, 1'b0);
        tick(0, 1'b0);
        chk("t2_count", 32'(cnt_w), 32'd1);

        // Down to 0, below it (wrap to 255 / saturate at 0), then wrap back up.
        detent_ccw(2, 1'b0);
        tick(0, 1'b0);
        chk("t3_zero", 32'(cnt_w), 32'd0);
        detent_ccw(2, 1'b0);
        tick(0, 1'b0);
        chk("t3_wrap_dn", 32'(cnt_w), 32'd255);
        chk("t3_sat_dn",  32'(cnt_s), 32'd0);
        detent_cw(1, 1'b0);
        tick(0, 1'b0);
        chk("t3_wrap_up", 32'(cnt_w), 32'd0);

        // Aborted detent, then an illegal 00->11 jump.
        tick(1, 1'b0); tick(0, 1'b0); tick(0, 1'b0);
        tick(2, 1'b0);
        tick(2, 1'b0);
        chk("t4_err", 32'(er_w), 32'd1);
        tick(3, 1'b0); tick(0, 1'b0); tick(0, 1'b0);

        // Count to 7, then a detent completing alongside a button rise.
        tick(0, 1'b1); tick(0, 1'b0);
        for (int i = 0; i < 7; i++) detent_cw(1, 1'b0);
        tick(0, 1'b0);
        chk("t5_seven", 32'(cnt_w), 32'd7);
        detent_cw(1, 1'b0);
        tick(0, 1'b1);
        chk("t5_up",    32'(up_w),  32'd1);
        chk("t5_press", 32'(pr_w),  32'd1);
        chk("t5_count", 32'(cnt_w), 32'd0);
        repeat (4) tick(0, 1'b1);
        tick(0, 1'b0);

        // Reset mid-detent: the finishing half must not step.
        tick(1, 1'b0); tick(2, 1'b0);
        do_reset(2, 1'b0);
        tick(2, 1'b0); tick(3, 1'b0); tick(0, 1'b0); tick(0, 1'b0);
        chk("t6_no_step", 32'(up_w), 32'd0);
        chk("t6_count",   32'(cnt_w), 32'd0);

        // Biased random walk with glitches, button activity and rare resets.
        bias = 2;
        bt   = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 256 == 0) bias = $urandom_range(0, 2);
            r = $urandom_range(0, 99);
            if (r < 3)       stp = 2;
            else if (r < 23) stp = 0;
            else begin
                th  = (bias == 0) ? 85 : (bias == 1) ? 15 : 50;
                stp = ($urandom_range(0, 99) < th) ? 1 : 3;
            end
            if ($urandom_range(0, 99) < 3) bt = ~bt;
            if ($urandom_range(0, 999) < 3) do_reset((r_pos + stp) % 4, bt);
            else tick((r_pos + stp) % 4, bt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
